// File: rtl/module_display_scan_if.sv
// Display scan port bundle: pattern load side plus segment/anode drive.
// master drives seg_data/load; slave is the scanner.
interface module_display_scan_if #(
    parameter int N_DIGITS = 4
);
    logic [7*N_DIGITS-1:0] seg_data;
    logic                  load;
    logic [6:0]            seg_out;
    logic [N_DIGITS-1:0]   anodo;
    logic                  frame_tick;
    logic                  upd_pending;

    modport master (
        output seg_data, load,
        input  seg_out, anodo, frame_tick, upd_pending
    );

    modport slave (
        input  seg_data, load,
        output seg_out, anodo, frame_tick, upd_pending
    );
endinterface

// File: rtl/module_display_scan.sv
// Multiplexed common-anode 7-segment scanner with frame-aligned double buffer.
// Define SCAN_BLANK_EN to insert BLANK_CYC dark cycles between digits.
module module_display_scan #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 27000,
    parameter int BLANK_CYC   = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    module_display_scan_if.slave bus
);
    localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CMAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CW   = $clog2(CMAX);

    localparam logic [CW-1:0] RD_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BC_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(N_DIGITS - 1);

    typedef enum logic {SHOW, BLANK} state_t;

    state_t                    state, state_nx;
    logic [CW-1:0]             div_cnt, div_nx;
    logic [IW-1:0]             idx, idx_nx;
    logic [N_DIGITS-1:0][6:0]  shadow, pending;
    logic                      upd, wrapped;
    logic                      adv, wrap;

    // div_cnt also times the dark gap while in BLANK
    always_comb begin
        state_nx = state;
        div_nx   = div_cnt + CW'(1);
        idx_nx   = idx;
        adv      = 1'b0;
        unique case (state)
            SHOW: begin
                if (div_cnt == RD_LAST) begin
                    div_nx = '0;
`ifdef SCAN_BLANK_EN
                    state_nx = BLANK;
`else
                    adv = 1'b1;
`endif
                end
            end
            BLANK: begin
                if (div_cnt == BC_LAST) begin
                    div_nx   = '0;
                    state_nx = SHOW;
                    adv      = 1'b1;
                end
            end
        endcase
        wrap = adv && (idx == I_LAST);
        if (adv) begin
            idx_nx = wrap ? '0 : idx + IW'(1);
        end
    end

    assign bus.upd_pending = upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= SHOW;
            div_cnt        <= '0;
            idx            <= '0;
            shadow         <= '0;
            pending        <= '0;
            upd            <= 1'b0;
            wrapped        <= 1'b0;
            bus.seg_out    <= '0;
            bus.anodo      <= '1;
            bus.frame_tick <= 1'b0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            idx     <= idx_nx;
            wrapped <= wrap;
            // a load on the commit edge lands in pending for the next frame
            if (wrap && upd) begin
                shadow <= pending;
            end
            if (bus.load) begin
                pending <= bus.seg_data;
            end
            upd <= bus.load | (upd & ~wrap);
            if (state == SHOW) begin
                bus.seg_out <= shadow[idx];
                bus.anodo   <= ~(N_DIGITS'(1) << idx);
            end else begin
                bus.seg_out <= '0;
                bus.anodo   <= '1;
            end
            bus.frame_tick <= wrapped;
        end
    end
endmodule
